// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned PC_W      = 3;
    localparam int unsigned NUM_INSTR = 7;
    localparam int unsigned DATA_W    = 32;

    // Width of the optional stall counter
    localparam int unsigned STALL_CNT_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } fetch_state_e;

endpackage

// File: rtl/fetch_stall_counter.sv
// Saturating event counter with synchronous clear and synchronous active-low reset.
module fetch_stall_counter #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Clear wins over increment; the count sticks at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives the combinational instruction memory
// address, registers the returned word and hands it to decode over valid/ready.
// Optional build macro FETCH_STALL_CNT_EN adds an 8-bit saturating stall counter.
module instr_fetch #(
    parameter int unsigned PC_W      = fetch_pkg::PC_W,
    parameter int unsigned NUM_INSTR = fetch_pkg::NUM_INSTR,
    parameter int unsigned DATA_W    = fetch_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [PC_W-1:0]   ip,
    input  logic [DATA_W-1:0] instruction,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
`ifdef FETCH_STALL_CNT_EN
    output logic              done,
    output logic [7:0]        stall_cnt
`else
    output logic              done
`endif
);

    import fetch_pkg::*;

    localparam logic [PC_W-1:0] LastPc = PC_W'(NUM_INSTR - 1);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   ip_q, ip_d;
    logic [PC_W-1:0]   out_pc_q, out_pc_d;
    logic [DATA_W-1:0] out_instr_q, out_instr_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;

    logic handshake;
    logic load;
    logic start_accept;

    assign handshake    = out_valid_q & out_ready;
    // Output register can take a new word when empty or being emptied this cycle.
    assign load         = (state_q == StRun) & (~out_valid_q | out_ready);
    assign start_accept = ((state_q == StIdle) | (state_q == StDone)) & start;

    // Next-state and next-output computation for the fetch FSM
    always_comb begin
        state_d     = state_q;
        ip_d        = ip_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_valid_d = out_valid_q;
        done_d      = done_q;

        if (handshake) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StRun;
                    ip_d    = '0;
                    done_d  = 1'b0;
                end
            end
            StRun: begin
                if (load) begin
                    out_instr_d = instruction;
                    out_pc_d    = ip_q;
                    out_valid_d = 1'b1;
                    // Never present an address past the last valid word.
                    if (ip_q == LastPc) begin
                        state_d = StDrain;
                    end else begin
                        ip_d = ip_q + PC_W'(1);
                    end
                end
            end
            StDrain: begin
                if (handshake) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ip_q        <= '0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ip_q        <= ip_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign ip        = ip_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

`ifdef FETCH_STALL_CNT_EN
    // Count cycles where decode back-pressures a held instruction.
    fetch_stall_counter #(
        .Width(STALL_CNT_W)
    ) u_stall_counter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (start_accept),
        .inc_i  (out_valid_q & ~out_ready),
        .cnt_o  (stall_cnt)
    );
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

    // Held instruction must not change or vanish while decode is stalling.
    a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_instr_q) && $stable(out_pc_q)));

    // The address bus never leaves the populated memory range.
    a_ip_range : assert property (@(posedge clk) disable iff (!rst_n) (ip_q <= LastPc));

    // done and out_valid are mutually exclusive.
    a_done_idle : assert property (@(posedge clk) disable iff (!rst_n) !(done_q && out_valid_q));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch paired with a 7-word instruction ROM.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  ip;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [2:0]  out_pc;
    logic        done;
`ifdef FETCH_STALL_CNT_EN
    logic [7:0]  stall_cnt;
`endif

    instr_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .ip          (ip),
        .instruction (instruction),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
`ifdef FETCH_STALL_CNT_EN
        .done        (done),
        .stall_cnt   (stall_cnt)
`else
        .done        (done)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected transfer table: address and the word stored there.
    typedef struct packed {
        logic [2:0]  pc;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs [7];

    // Instruction memory model, combinational read
    logic [31:0] rom [7];
    always_comb begin
        if (ip < 3'd7) instruction = rom[ip];
        else           instruction = 32'hDEAD_BEEF;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Decode-side observer
    int          xfer_cnt = 0;
    logic [2:0]  xfer_pc    [16];
    logic [31:0] xfer_instr [16];
    logic        ip_bad = 1'b0;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (xfer_cnt < 16) begin
                xfer_pc[xfer_cnt]    = out_pc;
                xfer_instr[xfer_cnt] = out_instr;
            end
            xfer_cnt = xfer_cnt + 1;
        end
        if (rst_n && ip >= 3'd7) ip_bad = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_run();
        xfer_cnt = 0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick();
            n++;
        end
        check("valid_reached", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic wait_done(input int budget, input bit rnd);
        int n = 0;
        while (!done && n < budget) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        out_ready = 1'b1;
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_xfers(input string tag);
        check({tag, "_xfer_count"}, xfer_cnt, 32'd7);
        for (int i = 0; i < 7 && i < xfer_cnt; i++) begin
            check({tag, "_xfer_pc"}, {29'd0, xfer_pc[i]}, {29'd0, vecs[i].pc});
            check({tag, "_xfer_instr"}, xfer_instr[i], vecs[i].instr);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rom[0] = 32'h2401_002D;
        rom[1] = 32'h2402_FFEC;
        rom[2] = 32'h0022_1820;
        rom[3] = 32'h0061_1822;
        rom[4] = 32'hAC03_0000;
        rom[5] = 32'h8C04_0000;
        rom[6] = 32'h1000_FFFF;
        vecs[0] = '{pc: 3'd0, instr: 32'h2401_002D};
        vecs[1] = '{pc: 3'd1, instr: 32'h2402_FFEC};
        vecs[2] = '{pc: 3'd2, instr: 32'h0022_1820};
        vecs[3] = '{pc: 3'd3, instr: 32'h0061_1822};
        vecs[4] = '{pc: 3'd4, instr: 32'hAC03_0000};
        vecs[5] = '{pc: 3'd5, instr: 32'h8C04_0000};
        vecs[6] = '{pc: 3'd6, instr: 32'h1000_FFFF};

        // Reset state
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_ip", {29'd0, ip}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_pc", {29'd0, out_pc}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        check("rst_stall_cnt", {24'd0, stall_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("idle_no_valid", {31'd0, out_valid}, 32'd0);

        // Full-rate run: one transfer per cycle straight from the table
        begin_run();
        wait_valid(4);
        for (int i = 0; i < 7; i++) begin
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_pc", {29'd0, out_pc}, {29'd0, vecs[i].pc});
            check("stream_instr", out_instr, vecs[i].instr);
            check("stream_not_done", {31'd0, done}, 32'd0);
            tick();
        end
        check("stream_done", {31'd0, done}, 32'd1);
        check("stream_drained", {31'd0, out_valid}, 32'd0);
        check_xfers("stream");

        // Start from DONE: done drops on the next cycle; then stall at out_pc=1
        begin_run();
        check("restart_done_low", {31'd0, done}, 32'd0);
`ifdef FETCH_STALL_CNT_EN
        check("restart_stall_clr", {24'd0, stall_cnt}, 32'd0);
`endif
        wait_valid(4);
        check("stall_pre_pc", {29'd0, out_pc}, 32'd0);
        tick();
        check("stall_pc1", {29'd0, out_pc}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
            check("stall_hold_pc", {29'd0, out_pc}, 32'd1);
            check("stall_hold_instr", out_instr, 32'h2402_FFEC);
            check("stall_hold_ip", {29'd0, ip}, 32'd2);
        end
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt_3", {24'd0, stall_cnt}, 32'd3);
`endif
        out_ready = 1'b1;
        wait_done(30, 1'b0);
        check_xfers("stall");

        // Random back-pressure
        begin_run();
        wait_done(300, 1'b1);
        check_xfers("random");

        // start during RUN is ignored
        begin_run();
        wait_valid(4);
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(30, 1'b0);
        check_xfers("start_in_run");
        tick();
        check("done_holds", {31'd0, done}, 32'd1);

        // Reset in the middle of a run, then refetch from address 0
        begin_run();
        wait_valid(4);
        for (int n = 0; n < 10 && out_pc != 3'd3; n++) tick();
        check("midrst_at_pc3", {29'd0, out_pc}, 32'd3);
        rst_n = 1'b0;
        tick();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_ip", {29'd0, ip}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_xfers", xfer_cnt, 32'd3);
        rst_n = 1'b1;
        tick();
        tick();
        check("midrst_idle", {31'd0, out_valid}, 32'd0);
        begin_run();
        wait_valid(4);
        check("refetch_pc", {29'd0, out_pc}, 32'd0);
        check("refetch_instr", out_instr, 32'h2401_002D);
        wait_done(30, 1'b0);
        check_xfers("refetch");

`ifdef FETCH_STALL_CNT_EN
        // Long stall saturates the counter instead of wrapping
        begin_run();
        check("sat_clr", {24'd0, stall_cnt}, 32'd0);
        out_ready = 1'b0;
        wait_valid(4);
        for (int i = 0; i < 300; i++) tick();
        check("sat_255", {24'd0, stall_cnt}, 32'd255);
        check("sat_hold_instr", out_instr, 32'h2401_002D);
        out_ready = 1'b1;
        wait_done(30, 1'b0);
        check_xfers("sat");
`endif

        check("ip_never_7", {31'd0, ip_bad}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
